os_dram_sched: RTL and testbench



---
 rtl/os_dram_sched_pkg.sv | 26 ++
 rtl/os_dram_sched_rec_cache.sv | 44 ++++
 rtl/os_dram_sched.sv | 183 ++++++++++++++++++
 tb/tb_os_dram_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/os_dram_sched_pkg.sv
// Shared types for the OS-core DRAM scheduler: FSM states, requester ids
// and the 64-bit record layout (Shop_Info high word, User_Info low word).
package os_dram_sched_pkg;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'd0,
        SCH_ISSUE = 2'd1,
        SCH_WAIT  = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_WB     = 2'd1,
        REQ_USER   = 2'd2,
        REQ_SELLER = 2'd3
    } dram_req_t;

    typedef logic [31:0] shop_info_t;
    typedef logic [31:0] user_info_t;

    typedef struct packed {
        shop_info_t shop;
        user_info_t user;
    } dram_rec_t;

endpackage

// File: rtl/os_dram_sched_rec_cache.sv
// One-entry record cache: holds the most recently read or written record
// so an immediate re-read can be answered without a bridge transaction.
module os_dram_sched_rec_cache
    import os_dram_sched_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 64,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data
);

    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr;
        end
    end

    // NOTE: the payload register has no reset; valid alone decides whether it is ever used.
    always_ff @(posedge clk) begin
        if (fill) begin
            data <= fill_data;
        end
    end

    assign hit      = CACHE_EN && valid && (tag == lookup_addr);
    assign hit_data = data;

endmodule

// File: rtl/os_dram_sched.sv
// Shares the single DRAM bridge port between write-back, user-read and
// seller-read requesters with fixed priority wb > ur > sr and one pending slot each.
module os_dram_sched
    import os_dram_sched_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 64,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_done,
    input  logic              ur_req,
    input  logic [ADDR_W-1:0] ur_addr,
    output logic              ur_valid,
    output logic [DATA_W-1:0] ur_data,
    input  logic              sr_req,
    input  logic [ADDR_W-1:0] sr_addr,
    output logic              sr_valid,
    output logic [DATA_W-1:0] sr_data,
    output logic              busy,
    output logic              req_drop,
    output logic              C_in_valid,
    output logic [ADDR_W-1:0] C_addr,
    output logic              C_r_wb,
    output logic [DATA_W-1:0] C_data_w,
    input  logic              C_out_valid,
    input  logic [DATA_W-1:0] C_data_r
);

    sched_state_t      state;
    dram_req_t         cur_req;
    logic              wb_pend, ur_pend, sr_pend;
    logic [ADDR_W-1:0] wb_slot_addr, ur_slot_addr, sr_slot_addr;
    logic [DATA_W-1:0] wb_slot_data;

    dram_req_t         grant;
    logic [ADDR_W-1:0] grant_addr;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              fill;
    logic [DATA_W-1:0] fill_data;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        grant      = REQ_NONE;
        grant_addr = wb_slot_addr;
        if (wb_pend) begin
            grant = REQ_WB;
        end else if (ur_pend) begin
            grant      = REQ_USER;
            grant_addr = ur_slot_addr;
        end else if (sr_pend) begin
            grant      = REQ_SELLER;
            grant_addr = sr_slot_addr;
        end
    end

    // Completion refreshes the cache: reads with bridge data, writes with the record just written.
    assign fill      = (state == SCH_WAIT) && C_out_valid;
    assign fill_data = C_r_wb ? C_data_r : C_data_w;

    os_dram_sched_rec_cache #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_addr (grant_addr),
        .hit         (hit),
        .hit_data    (hit_data),
        .fill        (fill),
        .fill_addr   (C_addr),
        .fill_data   (fill_data)
    );

    assign busy = wb_pend || ur_pend || sr_pend || (state != SCH_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SCH_IDLE;
            cur_req      <= REQ_NONE;
            wb_pend      <= 1'b0;
            ur_pend      <= 1'b0;
            sr_pend      <= 1'b0;
            wb_slot_addr <= '0;
            wb_slot_data <= '0;
            ur_slot_addr <= '0;
            sr_slot_addr <= '0;
            wb_done      <= 1'b0;
            ur_valid     <= 1'b0;
            ur_data      <= '0;
            sr_valid     <= 1'b0;
            sr_data      <= '0;
            req_drop     <= 1'b0;
            C_in_valid   <= 1'b0;
            C_addr       <= '0;
            C_r_wb       <= 1'b0;
            C_data_w     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
            wb_done    <= 1'b0;
            ur_valid   <= 1'b0;
            sr_valid   <= 1'b0;
            C_in_valid <= 1'b0;
            req_drop   <= (wb_req && wb_pend) || (ur_req && ur_pend) || (sr_req && sr_pend);

            // A slot stays occupied until its response pulse, so a new request here is dropped.
            if (wb_req && !wb_pend) begin
                wb_pend      <= 1'b1;
                wb_slot_addr <= wb_addr;
                wb_slot_data <= wb_data;
            end
            if (ur_req && !ur_pend) begin
                ur_pend      <= 1'b1;
                ur_slot_addr <= ur_addr;
            end
            if (sr_req && !sr_pend) begin
                sr_pend      <= 1'b1;
                sr_slot_addr <= sr_addr;
            end

            case (state)
                SCH_IDLE: begin
                    if (grant == REQ_WB) begin
                        C_in_valid <= 1'b1;
                        C_addr     <= wb_slot_addr;
                        C_r_wb     <= 1'b0;
                        C_data_w   <= wb_slot_data;
                        cur_req    <= REQ_WB;
                        state      <= SCH_ISSUE;
                    end else if (grant == REQ_USER && hit) begin
                        ur_data  <= hit_data;
                        ur_valid <= 1'b1;
                        ur_pend  <= 1'b0;
                    end else if (grant == REQ_SELLER && hit) begin
                        sr_data  <= hit_data;
                        sr_valid <= 1'b1;
                        sr_pend  <= 1'b0;
                    end else if (grant != REQ_NONE) begin
                        C_in_valid <= 1'b1;
                        C_addr     <= grant_addr;
                        C_r_wb     <= 1'b1;
                        cur_req    <= grant;
                        state      <= SCH_ISSUE;
                    end
                end
                SCH_ISSUE: begin
                    state <= SCH_WAIT;
                end
                SCH_WAIT: begin
                    if (C_out_valid) begin
                        case (cur_req)
                            REQ_WB: begin
                                wb_done <= 1'b1;
                                wb_pend <= 1'b0;
                            end
                            REQ_USER: begin
                                ur_data  <= C_data_r;
                                ur_valid <= 1'b1;
                                ur_pend  <= 1'b0;
                            end
                            REQ_SELLER: begin
                                sr_data  <= C_data_r;
                                sr_valid <= 1'b1;
                                sr_pend  <= 1'b0;
                            end
                            default: ;
                        endcase
                        cur_req <= REQ_NONE;
                        state   <= SCH_IDLE;
                    end
                end
                default: state <= SCH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_os_dram_sched.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a record-memory reference model and a behavioural DRAM bridge.
module tb_os_dram_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_req, ur_req, sr_req;
    logic [7:0]  wb_addr, ur_addr, sr_addr;
    logic [63:0] wb_data;
    logic        wb_done, ur_valid, sr_valid, busy, req_drop;
    logic [63:0] ur_data, sr_data;
    logic        C_in_valid, C_r_wb, C_out_valid;
    logic [7:0]  C_addr;
    logic [63:0] C_data_w, C_data_r;

    // Second instance with the cache disabled, driven only on its user-read port.
    logic        ur0_req;
    logic [7:0]  ur0_addr;
    logic        wb0_done, ur0_valid, sr0_valid, busy0, drop0;
    logic [63:0] ur0_data, sr0_data;
    logic        c0_in_valid, c0_r_wb, c0_out_valid;
    logic [7:0]  c0_addr;
    logic [63:0] c0_data_w;

    always #5 clk = ~clk;

    os_dram_sched #(.ADDR_W(8), .DATA_W(64), .CACHE_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_done(wb_done),
        .ur_req(ur_req), .ur_addr(ur_addr), .ur_valid(ur_valid), .ur_data(ur_data),
        .sr_req(sr_req), .sr_addr(sr_addr), .sr_valid(sr_valid), .sr_data(sr_data),
        .busy(busy), .req_drop(req_drop),
        .C_in_valid(C_in_valid), .C_addr(C_addr), .C_r_wb(C_r_wb), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r)
    );

    os_dram_sched #(.ADDR_W(8), .DATA_W(64), .CACHE_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wb_req(1'b0), .wb_addr(8'h00), .wb_data(64'h0), .wb_done(wb0_done),
        .ur_req(ur0_req), .ur_addr(ur0_addr), .ur_valid(ur0_valid), .ur_data(ur0_data),
        .sr_req(1'b0), .sr_addr(8'h00), .sr_valid(sr0_valid), .sr_data(sr0_data),
        .busy(busy0), .req_drop(drop0),
        .C_in_valid(c0_in_valid), .C_addr(c0_addr), .C_r_wb(c0_r_wb), .C_data_w(c0_data_w),
        .C_out_valid(c0_out_valid), .C_data_r(64'hFEED_F00D_1234_5678)
    );

    localparam logic [63:0] REC_05 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] REC_09 = 64'h5E11_E209_0000_0009;
    localparam logic [63:0] WB_07  = 64'hAAAA_0000_5555_FFFF;
    localparam logic [63:0] REC_C0 = 64'hFEED_F00D_1234_5678;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed record contents, updated when a write-back is acknowledged.
    logic [63:0] ref_mem [256];
    // Behavioural bridge storage.
    logic [63:0] bmem [256];

    bit          wb_out = 0, ur_out = 0, sr_out = 0;
    logic [7:0]  wb_a, ur_a, sr_a;
    logic [63:0] wb_d;
    bit          drop_now = 0;
    bit          mon_en = 0;
    bit          rand_delay = 0, spur_en = 0;
    int          resp_delay = 2;

    bit          br_busy = 0;
    int          br_cnt;
    logic [7:0]  br_addr;
    logic        br_rd;
    logic [63:0] br_wd;

    int          cyc = 0, cyc_outv = 0, cyc_urv = 0;
    int          n_cmd = 0, n_urv = 0, n_srv = 0, n_wbd = 0, n_drop = 0;
    logic [63:0] ur_last, sr_last;
    logic [8:0]  cmd_log [$];

    int          c0_cmds = 0, c0_pend = 0, n_ur0v = 0;
    logic [63:0] ur0_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drives one cycle of requests and records which ones the scheduler must accept.
    task automatic drive(input bit w, input logic [7:0] wa, input logic [63:0] wd,
                         input bit u, input logic [7:0] ua, input bit s, input logic [7:0] sa);
        wb_req = w; wb_addr = wa; wb_data = wd;
        ur_req = u; ur_addr = ua;
        sr_req = s; sr_addr = sa;
        if (w) begin
            if (wb_out) drop_now = 1;
            else begin wb_out = 1; wb_a = wa; wb_d = wd; end
        end
        if (u) begin
            if (ur_out) drop_now = 1;
            else begin ur_out = 1; ur_a = ua; end
        end
        if (s) begin
            if (sr_out) drop_now = 1;
            else begin sr_out = 1; sr_a = sa; end
        end
        step();
        wb_req = 0; ur_req = 0; sr_req = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((wb_out || ur_out || sr_out) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", {61'b0, wb_out, ur_out, sr_out}, 64'd0);
    endtask

    task automatic wait_cmd(input int budget);
        int n = 0;
        while (!br_busy && n < budget) begin
            step();
            n++;
        end
        check("cmd_timeout", br_busy, 1);
    endtask

    // Monitor, scoreboard and bridge model for the cached instance.
    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            C_out_valid = 1'b0;
        end else begin
            if (wb_done) begin
                check("wb_done_owner", wb_out, 1);
                ref_mem[wb_a] = wb_d;
                wb_out = 0;
                n_wbd++;
            end
            if (ur_valid) begin
                check("ur_valid_owner", ur_out, 1);
                check("ur_data", ur_data, ref_mem[ur_a]);
                ur_out = 0; ur_last = ur_data; cyc_urv = cyc; n_urv++;
            end
            if (sr_valid) begin
                check("sr_valid_owner", sr_out, 1);
                check("sr_data", sr_data, ref_mem[sr_a]);
                sr_out = 0; sr_last = sr_data; n_srv++;
            end
            check("req_drop", req_drop, drop_now);
            if (req_drop) n_drop++;
            drop_now = 0;
            check("busy", busy, wb_out || ur_out || sr_out);

            C_out_valid = 1'b0;
            if (C_in_valid) begin
                check("cmd_overlap", br_busy, 0);
                if (!C_r_wb) begin
                    check("cmd_wr_owner", wb_out, 1);
                    check("cmd_wr_addr", C_addr, wb_a);
                    check("cmd_wr_data", C_data_w, wb_d);
                end else begin
                    check("cmd_rd_owner", (ur_out && C_addr == ur_a) || (sr_out && C_addr == sr_a), 1);
                end
                br_busy = 1; br_addr = C_addr; br_rd = C_r_wb; br_wd = C_data_w;
                br_cnt  = rand_delay ? int'($urandom_range(0, 3)) : resp_delay;
                n_cmd++;
                cmd_log.push_back({C_r_wb, C_addr});
            end else if (br_busy) begin
                check("c_addr_hold", C_addr, br_addr);
                check("c_r_wb_hold", C_r_wb, br_rd);
                check("c_data_w_hold", C_data_w, br_wd);
                if (br_cnt == 0) begin
                    C_out_valid = 1'b1;
                    cyc_outv = cyc;
                    if (br_rd) C_data_r = bmem[br_addr];
                    else begin
                        bmem[br_addr] = br_wd;
                        C_data_r = {$urandom, $urandom};
                    end
                    br_busy = 0;
                end else begin
                    br_cnt--;
                end
            end else if (spur_en && $urandom_range(0, 15) == 0) begin
                C_out_valid = 1'b1;
                C_data_r = {$urandom, $urandom};
            end
        end
    end

    // Fixed-latency bridge for the cache-disabled instance.
    always @(negedge clk) begin
        c0_out_valid = 1'b0;
        if (ur0_valid) begin
            n_ur0v++;
            ur0_last = ur0_data;
        end
        if (c0_pend > 0) begin
            c0_pend--;
            if (c0_pend == 0) c0_out_valid = 1'b1;
        end
        if (c0_in_valid) begin
            c0_cmds++;
            c0_pend = 2;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cyc_req, prev;
        logic [8:0] entry;

        for (int i = 0; i < 256; i++) begin
            logic [63:0] v;
            v = {$urandom, $urandom};
            bmem[i] = v;
            ref_mem[i] = v;
        end
        bmem[5] = REC_05; ref_mem[5] = REC_05;
        bmem[9] = REC_09; ref_mem[9] = REC_09;

        rst_n = 0;
        wb_req = 0; ur_req = 0; sr_req = 0;
        wb_addr = 0; ur_addr = 0; sr_addr = 0; wb_data = 0;
        ur0_req = 0; ur0_addr = 0;
        C_out_valid = 0; C_data_r = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_c_in_valid", C_in_valid, 0);
        check("rst_ur_valid", ur_valid, 0);
        check("rst_ur_data", ur_data, 0);
        check("rst_wb_done", wb_done, 0);
        check("rst_req_drop", req_drop, 0);
        check("rst_c_addr", C_addr, 0);
        rst_n = 1;
        step();
        mon_en = 1;

        // Single user read, miss.
        resp_delay = 2;
        base = n_cmd;
        drive(0, 0, 0, 1, 8'h05, 0, 0);
        wait_idle(50);
        check("miss_cmd_count", n_cmd - base, 1);
        entry = (cmd_log.size() > base) ? cmd_log[base] : 9'h1FF;
        check("miss_cmd", entry, {1'b1, 8'h05});
        check("miss_valid_lat", cyc_urv - cyc_outv, 1);
        check("miss_data", ur_last, REC_05);

        // Re-read hits the cache.
        base = n_cmd;
        cyc_req = cyc;
        drive(0, 0, 0, 1, 8'h05, 0, 0);
        wait_idle(50);
        check("hit_cmd_count", n_cmd - base, 0);
        check("hit_latency", cyc_urv - cyc_req, 2);
        check("hit_data", ur_last, REC_05);

        // Simultaneous wb, ur (same address) and sr.
        base = n_cmd;
        prev = n_wbd;
        drive(1, 8'h07, WB_07, 1, 8'h07, 1, 8'h09);
        wait_idle(80);
        check("simul_cmd_count", n_cmd - base, 2);
        entry = (cmd_log.size() > base) ? cmd_log[base] : 9'h1FF;
        check("simul_first_write", entry, {1'b0, 8'h07});
        entry = (cmd_log.size() > base + 1) ? cmd_log[base + 1] : 9'h1FF;
        check("simul_second_read", entry, {1'b1, 8'h09});
        check("simul_wb_done", n_wbd - prev, 1);
        check("simul_ur_data", ur_last, WB_07);
        check("simul_sr_data", sr_last, REC_09);

        // Drop: second seller read while the first waits on the bridge.
        drive(0, 0, 0, 1, 8'h30, 0, 0);
        wait_idle(50);
        resp_delay = 4;
        prev = n_srv;
        base = n_drop;
        drive(0, 0, 0, 0, 0, 1, 8'h09);
        wait_cmd(20);
        step();
        drive(0, 0, 0, 0, 0, 1, 8'h0A);
        wait_idle(50);
        check("drop_count", n_drop - base, 1);
        check("drop_sr_valids", n_srv - prev, 1);
        check("drop_sr_data", sr_last, REC_09);

        // Reset while a read waits; cache must come back invalid.
        resp_delay = 2;
        drive(0, 0, 0, 1, 8'h05, 0, 0);
        wait_idle(50);
        resp_delay = 4;
        drive(0, 0, 0, 0, 0, 1, 8'h20);
        wait_cmd(20);
        step();
        mon_en = 0;
        rst_n = 0;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_c_in_valid", C_in_valid, 0);
        check("rstw_c_addr", C_addr, 0);
        check("rstw_c_r_wb", C_r_wb, 0);
        check("rstw_sr_valid", sr_valid, 0);
        check("rstw_ur_data", ur_data, 0);
        check("rstw_sr_data", sr_data, 0);
        wb_out = 0; ur_out = 0; sr_out = 0; br_busy = 0; drop_now = 0;
        step();
        step();
        rst_n = 1;
        step();
        mon_en = 1;
        resp_delay = 2;
        base = n_cmd;
        drive(0, 0, 0, 1, 8'h05, 0, 0);
        wait_idle(50);
        check("post_rst_miss", n_cmd - base, 1);
        check("post_rst_data", ur_last, REC_05);

        // Randomized traffic on a small address range for hits, conflicts and drops.
        rand_delay = 1;
        spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 5) == 0, 8'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 3) == 0, 8'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, 8'($urandom_range(0, 7)));
        end
        wait_idle(200);
        spur_en = 0;
        check("rand_drops_seen", n_drop > base, 1);

        // Cache disabled: two reads of the same record both use the bridge.
        base = c0_cmds;
        for (int k = 0; k < 2; k++) begin
            int n;
            prev = n_ur0v;
            ur0_req = 1; ur0_addr = 8'h05;
            step();
            ur0_req = 0;
            n = 0;
            while (n_ur0v == prev && n < 50) begin
                step();
                n++;
            end
            check("nocache_resp", n_ur0v - prev, 1);
            check("nocache_data", ur0_last, REC_C0);
        end
        check("nocache_cmds", c0_cmds - base, 2);
        step();
        check("nocache_idle", busy0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
